// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio sample widths, defaults and stereo packing order
package audio_pkg;

    localparam int PCM_W    = 8;
    localparam int STEREO_W = 2 * PCM_W;

    localparam logic [PCM_W-1:0] SILENCE_DEFAULT = 8'h80;
    localparam int unsigned PHASE_INC_44K1_50M = 32'd3788161;

    typedef logic [PCM_W-1:0]    pcm_t;
    typedef logic [STEREO_W-1:0] stereo_t;

    // Left channel always occupies the upper byte of a stereo word.
    function automatic stereo_t pack_stereo(input pcm_t left, input pcm_t right);
        return {left, right};
    endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - synchronous DEPTH x W FIFO with level, full and empty
module audio_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [W-1:0]                 wdata_i,
    output logic [W-1:0]                 rdata_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Power-of-two depth lets the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (do_push && !do_pop) level_d = level_q + LW'(1);
        if (do_pop && !do_push) level_d = level_q - LW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/audio_sample_pacer.sv
// rtl/audio_sample_pacer.sv - buffers stereo samples and releases one per NCO tick
module audio_sample_pacer
    import audio_pkg::*;
#(
    parameter int               DEPTH     = 4,
    parameter int               ACC_W     = 32,
    parameter logic [ACC_W-1:0] PHASE_INC = ACC_W'(PHASE_INC_44K1_50M),
    parameter logic [PCM_W-1:0] SILENCE   = SILENCE_DEFAULT
) (
    input  logic                         clk_pcm,
    input  logic                         aclr,
    input  logic                         enable,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PCM_W-1:0]             in_left,
    input  logic [PCM_W-1:0]             in_right,
    input  logic                         fifo_full,
    output logic [STEREO_W-1:0]          stereo_pcm,
    output logic                         stereo_pcm_rdy,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [15:0]                  underrun_count,
    output logic                         slot_lost
);

    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                pending_q, pending_d;
    logic [STEREO_W-1:0] pcm_q, pcm_d;
    logic                rdy_q, rdy_d;
    logic [15:0]         urc_q, urc_d;
    logic                lost_q, lost_d;

    logic [ACC_W:0]      acc_sum;
    logic                tick, emit;
    logic                buf_full, buf_empty, push, pop;
    logic [STEREO_W-1:0] head;

    assign in_ready = !buf_full;
    assign push     = in_valid && in_ready;
    assign pop      = emit && !buf_empty;

    audio_sample_fifo #(
        .DEPTH (DEPTH),
        .W     (STEREO_W)
    ) u_fifo (
        .clk_i   (clk_pcm),
        .rst_i   (aclr),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (pack_stereo(in_left, in_right)),
        .rdata_o (head),
        .level_o (level),
        .full_o  (buf_full),
        .empty_o (buf_empty)
    );

    assign acc_sum = {1'b0, acc_q} + {1'b0, PHASE_INC};
    assign tick    = enable && acc_sum[ACC_W];
    assign emit    = pending_q && !fifo_full && enable;

    always_comb begin
        acc_d     = acc_q;
        pending_d = pending_q;
        pcm_d     = pcm_q;
        rdy_d     = emit;
        urc_d     = urc_q;
        lost_d    = lost_q;
        if (enable) begin
            acc_d = acc_sum[ACC_W-1:0];
            // A tick coinciding with an emission re-arms the slot just consumed.
            if (emit) begin
                pending_d = tick;
            end else if (tick) begin
                pending_d = 1'b1;
                if (pending_q) lost_d = 1'b1;
            end
        end else begin
            acc_d     = '0;
            pending_d = 1'b0;
        end
        if (emit) begin
            if (!buf_empty) begin
                pcm_d = head;
            end else begin
                pcm_d = pack_stereo(SILENCE, SILENCE);
                if (urc_q != 16'hFFFF) urc_d = urc_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_pcm) begin
        if (aclr) begin
            acc_q     <= '0;
            pending_q <= 1'b0;
            pcm_q     <= pack_stereo(SILENCE, SILENCE);
            rdy_q     <= 1'b0;
            urc_q     <= '0;
            lost_q    <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            pending_q <= pending_d;
            pcm_q     <= pcm_d;
            rdy_q     <= rdy_d;
            urc_q     <= urc_d;
            lost_q    <= lost_d;
        end
    end

    assign stereo_pcm     = pcm_q;
    assign stereo_pcm_rdy = rdy_q;
    assign underrun_count = urc_q;
    assign slot_lost      = lost_q;

endmodule

// File: tb/tb_audio_sample_pacer.sv
// tb/tb_audio_sample_pacer.sv - directed and randomized checks against a queue-based reference model
module tb_audio_sample_pacer;

    localparam int      DEPTH = 4;
    localparam longint  INC   = 64'h4000_0000;
    localparam longint  MOD   = 64'h1_0000_0000;
    localparam longint  INC2  = 3788161;

    logic        clk_pcm = 1'b0;
    logic        aclr = 1'b1, enable = 1'b0, in_valid = 1'b0, fifo_full = 1'b0;
    logic [7:0]  in_left = '0, in_right = '0;
    logic        in_ready, stereo_pcm_rdy, slot_lost;
    logic [15:0] stereo_pcm, underrun_count;
    logic [2:0]  level;

    logic        aclr2 = 1'b1;
    logic        in_ready2, rdy2, lost2;
    logic [15:0] pcm2, urc2;
    logic [2:0]  level2;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk_pcm = ~clk_pcm;

    audio_sample_pacer #(.DEPTH(DEPTH), .ACC_W(32), .PHASE_INC(32'h4000_0000), .SILENCE(8'h80)) dut (
        .clk_pcm(clk_pcm), .aclr(aclr), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
        .in_left(in_left), .in_right(in_right), .fifo_full(fifo_full), .stereo_pcm(stereo_pcm),
        .stereo_pcm_rdy(stereo_pcm_rdy), .level(level), .underrun_count(underrun_count),
        .slot_lost(slot_lost));

    audio_sample_pacer dut2 (
        .clk_pcm(clk_pcm), .aclr(aclr2), .enable(1'b1), .in_valid(1'b1), .in_ready(in_ready2),
        .in_left(8'h11), .in_right(8'h22), .fifo_full(1'b0), .stereo_pcm(pcm2),
        .stereo_pcm_rdy(rdy2), .level(level2), .underrun_count(urc2), .slot_lost(lost2));

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: accumulator as plain integer arithmetic, buffer as a queue.
    longint     m_acc = 0;
    bit         m_pend = 0, m_rdy = 0, m_lost = 0, m_push = 0, m_tick, m_emit;
    int         m_urc = 0, m_lvl;
    bit [15:0]  m_pcm = 16'h8080;
    bit [15:0]  m_q[$];

    always @(posedge clk_pcm) begin
        if (aclr) begin
            m_acc = 0; m_pend = 0; m_rdy = 0; m_lost = 0; m_push = 0;
            m_urc = 0; m_pcm = 16'h8080; m_q.delete();
        end else begin
            m_lvl  = m_q.size();
            m_push = in_valid && (m_lvl < DEPTH);
            m_emit = 0;
            if (enable) begin
                m_acc  = m_acc + INC;
                m_tick = (m_acc >= MOD);
                if (m_tick) m_acc = m_acc - MOD;
                m_emit = m_pend && !fifo_full;
                if (m_emit) m_pend = m_tick;
                else if (m_tick) begin
                    if (m_pend) m_lost = 1;
                    m_pend = 1;
                end
            end else begin
                m_acc = 0; m_pend = 0;
            end
            m_rdy = m_emit;
            if (m_emit) begin
                if (m_lvl > 0) m_pcm = m_q.pop_front();
                else begin
                    m_pcm = 16'h8080;
                    if (m_urc < 65535) m_urc++;
                end
            end
            if (m_push) m_q.push_back({in_left, in_right});
        end
    end

    bit [15:0] strobes[$];
    longint    k2 = 0, n2 = 0;

    always @(posedge clk_pcm) if (!aclr2) k2++;

    always @(negedge clk_pcm) begin
        if (stereo_pcm_rdy) strobes.push_back(stereo_pcm);
        if (rdy2) n2++;
        check_eq("pcm", stereo_pcm, m_pcm);
        check_eq("rdy", stereo_pcm_rdy, m_rdy);
        check_eq("level", level, m_q.size());
        check_eq("in_ready", in_ready, m_q.size() < DEPTH);
        check_eq("underrun_count", underrun_count, m_urc);
        check_eq("slot_lost", slot_lost, m_lost);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_pcm);
        #1;
    endtask

    task automatic do_reset();
        aclr = 1; enable = 0; in_valid = 0; fifo_full = 0;
        cyc(2);
        aclr = 0;
    endtask

    int     k;
    bit     en_r, ff_r;
    int     vrate;
    longint exp2;

    initial begin
        do_reset();
        aclr2 = 0;
        check_eq("rst_level", level, 0);
        check_eq("rst_pcm", stereo_pcm, 16'h8080);
        check_eq("rst_rdy", stereo_pcm_rdy, 0);

        // Three buffered samples then an underrun, one strobe per 4-cycle tick.
        in_valid = 1;
        in_left = 8'd127; in_right = 8'd0;   cyc(1);
        in_left = 8'd0;   in_right = 8'd127; cyc(1);
        in_left = 8'd127; in_right = 8'd127; cyc(1);
        in_valid = 0;
        strobes.delete();
        enable = 1;
        cyc(20);
        check_eq("s1_count", strobes.size(), 4);
        if (strobes.size() == 4) begin
            check_eq("s1_w0", strobes[0], 16'h7F00);
            check_eq("s1_w1", strobes[1], 16'h007F);
            check_eq("s1_w2", strobes[2], 16'h7F7F);
            check_eq("s1_w3", strobes[3], 16'h8080);
        end
        check_eq("s1_urc", underrun_count, 1);

        // fifo_full spanning two ticks: withheld, slot lost, then one strobe.
        do_reset();
        in_valid = 1; in_left = 8'h3C; in_right = 8'hC3; cyc(1);
        in_valid = 0;
        strobes.delete();
        enable = 1; fifo_full = 1;
        cyc(10);
        check_eq("s2_none_while_full", strobes.size(), 0);
        check_eq("s2_lost", slot_lost, 1);
        fifo_full = 0;
        cyc(2);
        check_eq("s2_count", strobes.size(), 1);
        if (strobes.size() == 1) check_eq("s2_word", strobes[0], 16'h3CC3);

        // Reset mid-stream with three samples buffered.
        enable = 0; in_valid = 1; in_left = 8'h01; in_right = 8'h02;
        cyc(3);
        in_valid = 0;
        check_eq("s5_level3", level, 3);
        aclr = 1; cyc(1); aclr = 0;
        check_eq("s5_level", level, 0);
        check_eq("s5_pcm", stereo_pcm, 16'h8080);
        check_eq("s5_rdy", stereo_pcm_rdy, 0);
        check_eq("s5_urc", underrun_count, 0);
        check_eq("s5_lost", slot_lost, 0);

        // Back-pressure: fifth sample held until space frees after the first pop.
        do_reset();
        k = 0; in_valid = 1; in_left = 8'(k); in_right = ~8'(k);
        repeat (6) begin
            cyc(1);
            if (m_push) begin k++; in_left = 8'(k); in_right = ~8'(k); end
        end
        check_eq("s3_level", level, 4);
        check_eq("s3_in_ready", in_ready, 0);
        check_eq("s3_accepted", k, 4);
        enable = 1;
        repeat (8) begin
            cyc(1);
            if (m_push) begin k++; in_left = 8'(k); in_right = ~8'(k); end
        end
        check_eq("s3_accepted_after", k, 5);
        check_eq("s3_level_after", level, 4);
        in_valid = 0;

        // Push coincident with an underrun emission is not bypassed.
        do_reset();
        enable = 1;
        cyc(4);
        in_valid = 1; in_left = 8'hA5; in_right = 8'h5A;
        cyc(1);
        in_valid = 0;
        check_eq("s6_rdy", stereo_pcm_rdy, 1);
        check_eq("s6_pcm", stereo_pcm, 16'h8080);
        check_eq("s6_urc", underrun_count, 1);
        check_eq("s6_level", level, 1);
        cyc(4);
        check_eq("s6_rdy2", stereo_pcm_rdy, 1);
        check_eq("s6_pcm2", stereo_pcm, 16'hA55A);

        // Randomized traffic with bursts of enable/fifo_full and rare resets.
        do_reset();
        en_r = 1; ff_r = 0; vrate = 50;
        for (int i = 0; i < 20000; i++) begin
            if (i % 1000 == 0) vrate = $urandom_range(0, 100);
            if ($urandom_range(0, 199) == 0) en_r = !en_r;
            if ($urandom_range(0, 15) == 0)  ff_r = !ff_r;
            aclr      = ($urandom_range(0, 999) == 0);
            enable    = en_r;
            fifo_full = ff_r;
            in_valid  = ($urandom_range(1, 100) <= vrate);
            in_left   = 8'($urandom);
            in_right  = 8'($urandom);
            cyc(1);
        end
        aclr = 0; in_valid = 0;
        cyc(2);

        // Default-rate instance: strobe count tracks the NCO tick rate.
        exp2 = ((k2 - 1) * INC2) / MOD;
        check_eq("nco_rate", (n2 >= exp2 - 1) && (n2 <= exp2 + 1), 1);
        check_eq("nco_urc", urc2, 0);
        check_eq("nco_lost", lost2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
